// File: rtl/quad_core_reset_sequencer_pkg.sv
// Shared types and defaults for the quad-core reset sequencer and its per-core soft-reset timers.
package quad_core_reset_sequencer_pkg;

    localparam int NUM_CORES            = 4;
    localparam int DEF_LOCK_FILTER      = 4;
    localparam int DEF_HOLD_CYCLES      = 63;
    localparam int DEF_STAGGER_CYCLES   = 8;
    localparam int DEF_SOFT_CYCLES      = 16;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_FILTER    = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } state_e;

endpackage

// File: rtl/core_soft_reset_timer.sv
// Per-core soft-reset timer: load on request, count down to zero, abort clears immediately.
module core_soft_reset_timer
    import quad_core_reset_sequencer_pkg::*;
#(
    parameter int SOFT_CYCLES = DEF_SOFT_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_abort,
    output logic o_busy_nxt
);

    localparam int            CW       = $clog2(SOFT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(SOFT_CYCLES);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    // Abort beats load; the count stops at zero rather than wrapping.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_abort) begin
            w_cnt_nxt = '0;
        end else if (i_load) begin
            w_cnt_nxt = CNT_LOAD;
        end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CW'(1);
        end
    end

    // Exposed one cycle early so the parent can register the core reset directly.
    assign o_busy_nxt = (w_cnt_nxt != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/quad_core_reset_sequencer.sv
// Brings four cores out of reset in a staggered order once the PLL lock is stable,
// and serves per-core soft-reset requests while running.
module quad_core_reset_sequencer
    import quad_core_reset_sequencer_pkg::*;
#(
    parameter int LOCK_FILTER    = DEF_LOCK_FILTER,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int STAGGER_CYCLES = DEF_STAGGER_CYCLES,
    parameter int SOFT_CYCLES    = DEF_SOFT_CYCLES
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 iPllLocked,
    input  logic [NUM_CORES-1:0] iSoftReq,
    output logic [NUM_CORES-1:0] oCoreReset,
    output logic                 oAllRunning,
    output logic [2:0]           oState
);

    localparam int FW = $clog2(LOCK_FILTER + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int SW = $clog2(STAGGER_CYCLES + 1);

    localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER - 1);
    localparam logic [FW-1:0] FILT_MAX  = FW'(LOCK_FILTER);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
    localparam logic [SW-1:0] STAG_LAST = SW'(STAGGER_CYCLES - 1);
    localparam logic [SW-1:0] STAG_MAX  = SW'(STAGGER_CYCLES);
    localparam logic [1:0]    LAST_IDX  = 2'(NUM_CORES - 1);

    logic                 r_lock_meta;
    logic                 r_lock_sync;
    state_e               r_state;
    logic [FW-1:0]        r_filt_cnt;
    logic [HW-1:0]        r_hold_cnt;
    logic [SW-1:0]        r_stag_cnt;
    logic [1:0]           r_core_idx;
    logic [NUM_CORES-1:0] r_core_reset;
    logic                 r_all_running;

    state_e               w_state_nxt;
    logic [FW-1:0]        w_filt_cnt_nxt;
    logic [HW-1:0]        w_hold_cnt_nxt;
    logic [SW-1:0]        w_stag_cnt_nxt;
    logic [1:0]           w_core_idx_nxt;
    logic [1:0]           w_idx_inc;
    logic [NUM_CORES-1:0] w_core_reset_nxt;
    logic                 w_all_running_nxt;
    logic                 w_lock_loss;
    logic [NUM_CORES-1:0] w_soft_load;
    logic [NUM_CORES-1:0] w_busy_nxt;

    assign w_lock_loss = (r_state != ST_WAIT_LOCK) && !r_lock_sync;
    assign w_soft_load = (r_state == ST_RUN) ? iSoftReq : '0;

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_timer
        core_soft_reset_timer #(
            .SOFT_CYCLES (SOFT_CYCLES)
        ) u_timer (
            .i_clk      (Clock),
            .i_rst_n    (Reset),
            .i_load     (w_soft_load[gi]),
            .i_abort    (w_lock_loss),
            .o_busy_nxt (w_busy_nxt[gi])
        );
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_filt_cnt_nxt    = r_filt_cnt;
        w_hold_cnt_nxt    = r_hold_cnt;
        w_stag_cnt_nxt    = r_stag_cnt;
        w_core_idx_nxt    = r_core_idx;
        w_core_reset_nxt  = r_core_reset;
        w_idx_inc         = r_core_idx + 2'd1;
        w_all_running_nxt = (r_state == ST_RUN) && (r_core_reset == '0);

        if (w_lock_loss) begin
            w_state_nxt      = ST_WAIT_LOCK;
            w_filt_cnt_nxt   = '0;
            w_hold_cnt_nxt   = '0;
            w_stag_cnt_nxt   = '0;
            w_core_idx_nxt   = '0;
            w_core_reset_nxt = '1;
        end else begin
            unique case (r_state)
                ST_WAIT_LOCK: begin
                    w_filt_cnt_nxt   = '0;
                    w_hold_cnt_nxt   = '0;
                    w_stag_cnt_nxt   = '0;
                    w_core_idx_nxt   = '0;
                    w_core_reset_nxt = '1;
                    if (r_lock_sync) begin
                        w_state_nxt = ST_FILTER;
                    end
                end
                ST_FILTER: begin
                    if (r_filt_cnt == FILT_LAST) begin
                        w_state_nxt    = ST_HOLD;
                        w_filt_cnt_nxt = '0;
                        w_hold_cnt_nxt = '0;
                    end else if (r_filt_cnt != FILT_MAX) begin
                        w_filt_cnt_nxt = r_filt_cnt + FW'(1);
                    end
                end
                ST_HOLD: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        w_state_nxt         = ST_RELEASE;
                        w_hold_cnt_nxt      = '0;
                        w_stag_cnt_nxt      = '0;
                        w_core_idx_nxt      = '0;
                        w_core_reset_nxt[0] = 1'b0;
                    end else if (r_hold_cnt != HOLD_MAX) begin
                        w_hold_cnt_nxt = r_hold_cnt + HW'(1);
                    end
                end
                // One shared stagger counter walks the core index; the last release enters RUN.
                ST_RELEASE: begin
                    if (r_stag_cnt == STAG_LAST) begin
                        w_stag_cnt_nxt              = '0;
                        w_core_idx_nxt              = w_idx_inc;
                        w_core_reset_nxt[w_idx_inc] = 1'b0;
                        if (w_idx_inc == LAST_IDX) begin
                            w_state_nxt = ST_RUN;
                        end
                    end else if (r_stag_cnt != STAG_MAX) begin
                        w_stag_cnt_nxt = r_stag_cnt + SW'(1);
                    end
                end
                ST_RUN: begin
                    w_core_reset_nxt = w_busy_nxt;
                end
                default: begin
                    w_state_nxt      = ST_WAIT_LOCK;
                    w_core_reset_nxt = '1;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_lock_meta   <= 1'b0;
            r_lock_sync   <= 1'b0;
            r_state       <= ST_WAIT_LOCK;
            r_filt_cnt    <= '0;
            r_hold_cnt    <= '0;
            r_stag_cnt    <= '0;
            r_core_idx    <= '0;
            r_core_reset  <= '1;
            r_all_running <= 1'b0;
        end else begin
            r_lock_meta   <= iPllLocked;
            r_lock_sync   <= r_lock_meta;
            r_state       <= w_state_nxt;
            r_filt_cnt    <= w_filt_cnt_nxt;
            r_hold_cnt    <= w_hold_cnt_nxt;
            r_stag_cnt    <= w_stag_cnt_nxt;
            r_core_idx    <= w_core_idx_nxt;
            r_core_reset  <= w_core_reset_nxt;
            r_all_running <= w_all_running_nxt;
        end
    end

    assign oCoreReset  = r_core_reset;
    assign oAllRunning = r_all_running;
    assign oState      = r_state;

endmodule

// File: doc/quad_core_reset_sequencer.md
QUAD_CORE_RESET_SEQUENCER -- requirements
Module: quad_core_reset_sequencer

Interface
REQ-001 SHALL have parameter LOCK_FILTER, default 4: consecutive cycles iPllLocked must be high before the lock is accepted.
REQ-002 SHALL have parameter HOLD_CYCLES, default 63: cycles all cores stay in reset after lock is accepted (BRAM init margin).
REQ-003 SHALL have parameter STAGGER_CYCLES, default 8: cycles between successive core releases.
REQ-004 SHALL have parameter SOFT_CYCLES, default 16: length of a per-core soft reset.
REQ-005 SHALL have port Clock, input, 1: sole clock, all logic on its rising edge.
REQ-006 SHALL have port Reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port iPllLocked, input, 1: PLL LOCKED, treated as asynchronous and synchronised internally by 2 flops.
REQ-008 SHALL have port iSoftReq, input, 4: per-core soft-reset request, single-cycle pulse per bit.
REQ-009 SHALL have port oCoreReset, output, 4: active-high reset to core i on bit i.
REQ-010 SHALL have port oAllRunning, output, 1: high when all four cores are out of reset.
REQ-011 SHALL have port oState, output, 3: current state encoding, for debug.

Function
REQ-012 SHALL implement states WAIT_LOCK=0, FILTER=1, HOLD=2, RELEASE=3, RUN=4.
REQ-013 WAIT_LOCK SHALL go to FILTER when the synchronised lock is 1.
REQ-014 FILTER SHALL go to HOLD after LOCK_FILTER consecutive lock=1 cycles.
REQ-015 FILTER SHALL return to WAIT_LOCK on any lock=0 cycle.
REQ-016 HOLD SHALL count HOLD_CYCLES cycles, then enter RELEASE with core index 0.
REQ-017 On entry to RELEASE, SHALL clear oCoreReset[0].
REQ-018 In RELEASE, SHALL clear oCoreReset[k] STAGGER_CYCLES cycles after oCoreReset[k-1] was cleared.
REQ-019 SHALL enter RUN in the cycle oCoreReset[3] is cleared.
REQ-020 SHALL treat a synchronised lock=0 in FILTER, HOLD, RELEASE or RUN as lock loss.
REQ-021 On lock loss, in the next cycle, SHALL set oCoreReset=4'b1111, cancel all soft resets, clear all counters and enter WAIT_LOCK.
REQ-022 In RUN, iSoftReq[i]=1 SHALL set oCoreReset[i] the next cycle and hold it exactly SOFT_CYCLES cycles; other cores SHALL be unaffected.
REQ-023 Simultaneous requests on several bits SHALL be served independently and in parallel.
REQ-024 A request on a core already in soft reset SHALL restart that core's count at SOFT_CYCLES.
REQ-025 iSoftReq SHALL be ignored outside RUN; lock loss SHALL take priority over a same-cycle soft request.
REQ-026 oAllRunning SHALL equal (state==RUN) && (oCoreReset==0), registered.
REQ-027 All counters SHALL be sized $clog2(param+1) and SHALL saturate; they SHALL never wrap.
REQ-028 All outputs SHALL be registered; oCoreReset SHALL be glitch-free.

Reset
REQ-029 Asserting Reset (low) SHALL asynchronously force state=WAIT_LOCK, oCoreReset=4'b1111, oAllRunning=0 and oState=0.
REQ-030 Asserting Reset SHALL clear all counters and the lock synchroniser.
REQ-031 Reset deassertion SHALL be handled synchronously; the first state change SHALL occur no earlier than the 3rd Clock edge after release.
REQ-032 Reset asserted mid-RELEASE or mid-soft-reset SHALL abort the sequence with no partial release.

Structure
REQ-033 A shared package SHALL hold the state enum (3-bit), the default parameter constants and NUM_CORES=4.
REQ-034 SHALL use sub-module core_soft_reset_timer (one per core): load on request, count down, output busy, cleared by abort.
REQ-035 The release stagger SHALL use a single shared counter plus a 2-bit core index; this logic SHALL NOT be replicated per core.

Verification
REQ-036 Lock rises at cycle 10 (defaults) -> FILTER at 13, HOLD at 17; oCoreReset bits clear at 80/88/96/104; oAllRunning=1 at 105.
REQ-037 Lock glitches low for 1 cycle during FILTER -> back to WAIT_LOCK, filter restarts, release timing shifts accordingly.
REQ-038 In RUN, iSoftReq=4'b0101 -> oCoreReset=4'b0101 for 16 cycles, then 0; oAllRunning low for those cycles.
REQ-039 In RUN, iSoftReq[2] re-pulsed 5 cycles after the first pulse -> core 2 held 21 cycles total.
REQ-040 Lock drops while core 1 is being released -> next cycle oCoreReset=4'b1111 and oState=0; full sequence repeats on relock.
REQ-041 Reset pulsed low mid-RUN, asynchronously between edges -> outputs reach reset values immediately with no Clock edge.
